countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 42 ++++
 rtl/down_counter.sv | 34 +++
 rtl/countdown_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state type, BCD digit limits and load-value clamping
// used by countdown_timer and its per-digit down_counter instances.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0]  BCD_UNITS_MAX    = 4'd9;
    localparam logic [3:0]  BCD_SEC_TENS_MAX = 4'd5;
    localparam logic [15:0] TIME_ZERO        = 16'h0000;
    localparam logic [15:0] TIME_ONE         = 16'h0001;

    // Digits are clamped individually first; the minutes pair is then limited
    // as a whole, so a minutes-tens digit above 9 always ends up at maxMin.
    function automatic logic [15:0] clampLoad(
        input logic [15:0] val,
        input logic [7:0]  maxMin,
        input logic [3:0]  maxMinTens,
        input logic [3:0]  maxMinUnits
    );
        logic [3:0] minTens;
        logic [3:0] minUnits;
        logic [3:0] secTens;
        logic [3:0] secUnits;
        logic [7:0] minutes;
        minTens  = val[15:12];
        minUnits = (val[11:8] > BCD_UNITS_MAX)    ? BCD_UNITS_MAX    : val[11:8];
        secTens  = (val[7:4]  > BCD_SEC_TENS_MAX) ? BCD_SEC_TENS_MAX : val[7:4];
        secUnits = (val[3:0]  > BCD_UNITS_MAX)    ? BCD_UNITS_MAX    : val[3:0];
        minutes  = ({4'd0, minTens} * 8'd10) + {4'd0, minUnits};
        if (minutes > maxMin) begin
            minTens  = maxMinTens;
            minUnits = maxMinUnits;
        end
        return {minTens, minUnits, secTens, secUnits};
    endfunction

endpackage

// File: rtl/down_counter.sv
// down_counter: one BCD digit that decrements on borrow-in, wraps from 0 to
// WRAP, loads synchronously and flags when it sits at 0.
module down_counter
    import timer_pkg::*;
#(
    parameter logic [3:0] WRAP = BCD_UNITS_MAX
) (
    input  logic       clk,
    input  logic       res,
    input  logic       i_load,
    input  logic [3:0] i_loadVal,
    input  logic       i_borrowIn,
    output logic [3:0] o_digit,
    output logic       o_min
);

    logic [3:0] r_digit;

    // Load wins over borrow so a reload on the expiry edge is never mixed
    // with a decrement.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= i_loadVal;
        end else if (i_borrowIn) begin
            r_digit <= (r_digit == 4'd0) ? WRAP : (r_digit - 4'd1);
        end
    end

    assign o_digit = r_digit;
    assign o_min   = (r_digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown with IDLE/RUN/PAUSE/DONE control.
// Define COUNTDOWN_AUTORELOAD_EN to reload from the last loaded value on expiry.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ena,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] cnt,
    output logic        zero,
    output logic        running,
    output logic        done
);

    localparam logic [7:0] MAX_MIN_V     = 8'(MAX_MIN);
    localparam logic [3:0] MAX_MIN_TENS  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_UNITS = 4'(MAX_MIN % 10);

    timer_state_t r_state;
    timer_state_t w_stateNext;
    logic         r_done;
    logic [15:0]  w_clamped;
    logic [15:0]  w_loadValue;
    logic         w_digitLoad;
    logic         w_tick;
    logic         w_expire;
    logic         w_atOne;
    logic         w_suMin;
    logic         w_stMin;
    logic         w_muMin;
    logic         w_mtMin;
    logic [3:0]   w_secUnits;
    logic [3:0]   w_secTens;
    logic [3:0]   w_minUnits;
    logic [3:0]   w_minTens;

    assign w_clamped = clampLoad(load_val, MAX_MIN_V, MAX_MIN_TENS, MAX_MIN_UNITS);
    assign cnt       = {w_minTens, w_minUnits, w_secTens, w_secUnits};
    assign zero      = w_suMin & w_stMin & w_muMin & w_mtMin;
    assign w_atOne   = (cnt == TIME_ONE);
    assign running   = (r_state == ST_RUN);
    assign done      = r_done;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [15:0] r_reload;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_reload <= TIME_ZERO;
        end else if (load) begin
            r_reload <= w_clamped;
        end
    end
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_done  <= w_expire;
        end
    end

    // Priority chain load > stop > start > ena; a strobe that is ignored in
    // the current state lets the next lower one through.
    always_comb begin
        w_stateNext = r_state;
        w_digitLoad = 1'b0;
        w_loadValue = w_clamped;
        w_tick      = 1'b0;
        w_expire    = 1'b0;
        if (load) begin
            w_stateNext = ST_IDLE;
            w_digitLoad = 1'b1;
        end else if (stop && (r_state == ST_RUN)) begin
            w_stateNext = ST_PAUSE;
        end else if (start && !zero &&
                     ((r_state == ST_IDLE) || (r_state == ST_PAUSE))) begin
            w_stateNext = ST_RUN;
        end else if (ena && (r_state == ST_RUN) && !zero) begin
            w_tick = 1'b1;
            if (w_atOne) begin
                w_expire = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (r_reload != TIME_ZERO) begin
                    w_tick      = 1'b0;
                    w_digitLoad = 1'b1;
                    w_loadValue = r_reload;
                end else begin
                    w_stateNext = ST_DONE;
                end
`else
                w_stateNext = ST_DONE;
`endif
            end
        end
    end

    down_counter #(.WRAP(BCD_UNITS_MAX)) u_secUnits (
        .clk        (clk),
        .res        (res),
        .i_load     (w_digitLoad),
        .i_loadVal  (w_loadValue[3:0]),
        .i_borrowIn (w_tick),
        .o_digit    (w_secUnits),
        .o_min      (w_suMin)
    );

    down_counter #(.WRAP(BCD_SEC_TENS_MAX)) u_secTens (
        .clk        (clk),
        .res        (res),
        .i_load     (w_digitLoad),
        .i_loadVal  (w_loadValue[7:4]),
        .i_borrowIn (w_tick & w_suMin),
        .o_digit    (w_secTens),
        .o_min      (w_stMin)
    );

    down_counter #(.WRAP(BCD_UNITS_MAX)) u_minUnits (
        .clk        (clk),
        .res        (res),
        .i_load     (w_digitLoad),
        .i_loadVal  (w_loadValue[11:8]),
        .i_borrowIn (w_tick & w_suMin & w_stMin),
        .o_digit    (w_minUnits),
        .o_min      (w_muMin)
    );

    down_counter #(.WRAP(BCD_UNITS_MAX)) u_minTens (
        .clk        (clk),
        .res        (res),
        .i_load     (w_digitLoad),
        .i_loadVal  (w_loadValue[15:12]),
        .i_borrowIn (w_tick & w_suMin & w_stMin & w_muMin),
        .o_digit    (w_minTens),
        .o_min      (w_mtMin)
    );

endmodule
